// File: rtl/vga_rx_monitor.sv
// 640x480 VGA receive monitor: sync-edge coordinate recovery, timing lock and pixel capture.
// Optional per-frame pixel signature is enabled by defining VGA_RX_CRC_EN.
module vga_rx_monitor #(
   parameter int H_DISP      = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_DISP      = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter int LOCK_FRAMES = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        p_tick,
   input  logic        hsync,
   input  logic        vsync,
   input  logic [2:0]  rgb,
   output logic        locked,
   output logic        pix_valid,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic [2:0]  pix_rgb,
   output logic        frame_tick,
   output logic [7:0]  err_cnt,
   output logic [15:0] frame_crc
);

   localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
   localparam int H_SS    = H_DISP + H_FP;
   localparam int V_SS    = V_DISP + V_FP;
   localparam int LL_MAX  = 2 * H_TOTAL;
   localparam int LL_W    = $clog2(LL_MAX + 1);
   localparam int LN_W    = $clog2(V_TOTAL + 2);

   typedef enum logic [1:0] {HUNT, ACQ, LOCKED} state_t;

   state_t           r_state, w_state_nxt;
   logic [3:0]       r_good, w_good_nxt;
   logic             r_hsync_d, r_vsync_d;
   logic [9:0]       r_h_cnt, r_v_cnt;
   logic [LL_W-1:0]  r_line_len;
   logic [LN_W-1:0]  r_line_num;
   logic             r_h_armed, r_v_armed;
   logic [7:0]       r_err_cnt;
   logic             r_pix_valid, r_frame_tick;
   logic [9:0]       r_pix_x, r_pix_y;
   logic [2:0]       r_pix_rgb;

   logic w_hs_edge, w_vs_edge, w_h_wrap, w_active;
   logic w_h_err, w_v_err, w_timeout, w_err;
   logic w_err_inc, w_tick, w_hunt_entry, w_locked;

   assign w_hs_edge = p_tick & hsync & ~r_hsync_d;
   assign w_vs_edge = p_tick & vsync & ~r_vsync_d;
   assign w_h_wrap  = (r_h_cnt == 10'(H_TOTAL - 1));
   assign w_active  = (r_h_cnt < 10'(H_DISP)) && (r_v_cnt < 10'(V_DISP));
   assign w_h_err   = w_hs_edge & r_h_armed & (r_line_len != LL_W'(H_TOTAL));
   assign w_v_err   = w_vs_edge & r_v_armed & (r_line_num != LN_W'(V_TOTAL));
   // Fires only on the tick that brings line_len to saturation, so a stuck sync reports once.
   assign w_timeout = p_tick & ~w_hs_edge & (r_line_len == LL_W'(LL_MAX - 1));
   assign w_err     = w_h_err | w_v_err | w_timeout;
   assign w_locked  = (r_state == LOCKED);

   always_comb begin
      w_state_nxt = r_state;
      w_good_nxt  = r_good;
      w_err_inc   = 1'b0;
      w_tick      = 1'b0;
      case (r_state)
         HUNT: begin
            if (w_vs_edge) begin
               w_state_nxt = ACQ;
               w_good_nxt  = '0;
            end
         end
         ACQ: begin
            if (w_err) begin
               w_state_nxt = HUNT;
            end else if (w_vs_edge) begin
               w_good_nxt = r_good + 4'd1;
               if (r_good + 4'd1 == 4'(LOCK_FRAMES)) w_state_nxt = LOCKED;
            end
         end
         LOCKED: begin
            if (w_err) begin
               w_state_nxt = HUNT;
               w_err_inc   = 1'b1;
            end else if (w_vs_edge) begin
               w_tick = 1'b1;
            end
         end
         default: w_state_nxt = HUNT;
      endcase
   end

   assign w_hunt_entry = (w_state_nxt == HUNT) && (r_state != HUNT);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= HUNT;
         r_good     <= '0;
         r_hsync_d  <= 1'b0;
         r_vsync_d  <= 1'b0;
         r_h_cnt    <= '0;
         r_v_cnt    <= '0;
         r_line_len <= '0;
         r_line_num <= '0;
         r_h_armed  <= 1'b0;
         r_v_armed  <= 1'b0;
         r_err_cnt  <= '0;
      end else if (p_tick) begin
         r_state   <= w_state_nxt;
         r_good    <= w_good_nxt;
         r_hsync_d <= hsync;
         r_vsync_d <= vsync;

         if (w_hs_edge)     r_h_cnt <= 10'(H_SS + 1);
         else if (w_h_wrap) r_h_cnt <= '0;
         else               r_h_cnt <= r_h_cnt + 10'd1;

         if (w_vs_edge)
            r_v_cnt <= 10'(V_SS);
         else if (!w_hs_edge && w_h_wrap)
            r_v_cnt <= (r_v_cnt == 10'(V_TOTAL - 1)) ? '0 : r_v_cnt + 10'd1;

         if (w_hs_edge)                        r_line_len <= LL_W'(1);
         else if (r_line_len != LL_W'(LL_MAX)) r_line_len <= r_line_len + LL_W'(1);

         if (w_vs_edge)
            r_line_num <= {{(LN_W-1){1'b0}}, w_hs_edge};
         else if (w_hs_edge && r_line_num != LN_W'(V_TOTAL + 1))
            r_line_num <= r_line_num + LN_W'(1);

         if (w_hunt_entry) begin
            r_h_armed <= 1'b0;
            r_v_armed <= 1'b0;
         end else begin
            if (w_hs_edge) r_h_armed <= 1'b1;
            if (w_vs_edge) r_v_armed <= 1'b1;
         end

         if (w_err_inc && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pix_valid  <= 1'b0;
         r_frame_tick <= 1'b0;
         r_pix_x      <= '0;
         r_pix_y      <= '0;
         r_pix_rgb    <= '0;
      end else begin
         r_pix_valid  <= p_tick & w_locked & w_active;
         r_frame_tick <= w_tick;
         if (p_tick && w_locked && w_active) begin
            r_pix_x   <= r_h_cnt;
            r_pix_y   <= r_v_cnt;
            r_pix_rgb <= rgb;
         end
      end
   end

`ifdef VGA_RX_CRC_EN
   logic [15:0] r_crc, r_frame_crc;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_crc       <= '0;
         r_frame_crc <= '0;
      end else if (p_tick) begin
         if (w_vs_edge) begin
            r_frame_crc <= r_crc;
            r_crc       <= '0;
         end else if (w_active) begin
            r_crc <= {r_crc[14:0], r_crc[15]} ^ {13'b0, rgb};
         end
      end
   end

   assign frame_crc = r_frame_crc;
`else
   assign frame_crc = '0;
`endif

   assign locked     = w_locked;
   assign pix_valid  = r_pix_valid;
   assign pix_x      = r_pix_x;
   assign pix_y      = r_pix_y;
   assign pix_rgb    = r_pix_rgb;
   assign frame_tick = r_frame_tick;
   assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Scoreboard bench for vga_rx_monitor on a shrunken 16x11 raster (8x6 active).
module tb_vga_rx_monitor;

   localparam int HD = 8, HF = 2, HSY = 3, HB = 3;
   localparam int VD = 6, VF = 1, VSY = 2, VB = 2;
   localparam int HT = 16, VT = 11, HSS = 10, VSS = 7;
`ifdef VGA_RX_CRC_EN
   localparam logic [15:0] CRC_MASK = 16'hFFFF;
`else
   localparam logic [15:0] CRC_MASK = 16'h0000;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        p_tick = 1'b0;
   logic        hsync = 1'b0;
   logic        vsync = 1'b0;
   logic [2:0]  rgb = 3'b000;
   logic        locked, pix_valid, frame_tick;
   logic [9:0]  pix_x, pix_y;
   logic [2:0]  pix_rgb;
   logic [7:0]  err_cnt;
   logic [15:0] frame_crc;

   always #5 clk = ~clk;

   vga_rx_monitor #(
      .H_DISP(HD), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
      .V_DISP(VD), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
      .LOCK_FRAMES(2)
   ) dut (
      .clk(clk), .reset_n(reset_n), .p_tick(p_tick),
      .hsync(hsync), .vsync(vsync), .rgb(rgb),
      .locked(locked), .pix_valid(pix_valid),
      .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
      .frame_tick(frame_tick), .err_cnt(err_cnt), .frame_crc(frame_crc)
   );

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic [2:0] c;
   } pix_t;

   pix_t        pix_q[$];
   logic [15:0] crc_q[$];
   pix_t        m_pix;
   logic [15:0] m_crc;
   int          n_cmp = 0;
   int          n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] pat(input int mode, input int x, input int y);
      case (mode)
         1: return (x == 3 && y == 2) ? 3'b101 : 3'b000;
         2: return (x == 0 && y == 0) ? 3'b001 : 3'b000;
         3: return (x == 0 && y == 0) ? 3'b010 : ((x == 7 && y == 5) ? 3'b111 : 3'b000);
         default: return 3'b000;
      endcase
   endfunction

   task automatic drive(input logic hs, input logic vs, input logic [2:0] c);
      @(negedge clk);
      hsync  = hs;
      vsync  = vs;
      rgb    = c;
      p_tick = 1'b1;
      @(negedge clk);
      p_tick = 1'b0;
   endtask

   // One raster, rows 0..VT-1; the vsync edge sits at row VSS, column 0. Negative row args disable a feature.
   task automatic run_frame(input int mode, input bit exp_pix, input bit exp_tick,
                            input logic [15:0] exp_crc, input int long_row,
                            input int stuck_row, input int pause_row, input int reset_row);
      bit         act;
      logic       hs, vs;
      logic [2:0] c;
      pix_t       p;
      for (int y = 0; y < VT; y++) begin
         vs = (y >= VSS) && (y < VSS + VSY);
         for (int x = 0; x < HT; x++) begin
            act = (x < HD) && (y < VD);
            hs  = (x >= HSS) && (x < HSS + HSY) && !(stuck_row >= 0 && y >= stuck_row);
            c   = act ? pat(mode, x, y) : 3'b110;
            if (exp_pix && act && (reset_row < 0 || y <= reset_row)) begin
               p.x = 10'(x);
               p.y = 10'(y);
               p.c = c;
               pix_q.push_back(p);
            end
            if (exp_tick && y == VSS && x == 0) crc_q.push_back(exp_crc & CRC_MASK);
            drive(hs, vs, c);
         end
         if (y == long_row) drive(1'b0, vs, 3'b110);
         if (y == pause_row) begin
            repeat (100) @(negedge clk);
            check("pause_frozen_locked", 32'(locked), 32'd1);
         end
         if (stuck_row >= 0 && y == stuck_row) check("stuck_not_yet_timed_out", 32'(locked), 32'd1);
         if (y == reset_row) begin
            reset_n = 1'b0;
            #1;
            check("rst_locked", 32'(locked), 32'd0);
            check("rst_pix_valid", 32'(pix_valid), 32'd0);
            check("rst_pix_x", 32'(pix_x), 32'd0);
            check("rst_pix_y", 32'(pix_y), 32'd0);
            check("rst_pix_rgb", 32'(pix_rgb), 32'd0);
            check("rst_frame_tick", 32'(frame_tick), 32'd0);
            check("rst_err_cnt", 32'(err_cnt), 32'd0);
            check("rst_frame_crc", 32'(frame_crc), 32'd0);
            repeat (3) @(negedge clk);
            reset_n = 1'b1;
         end
      end
   endtask

   always @(negedge clk) begin
      if (pix_valid) begin
         if (pix_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_pix: got x=%0d y=%0d rgb=%0d, expected no pixel", pix_x, pix_y, pix_rgb);
         end else begin
            m_pix = pix_q.pop_front();
            check("pix_x", 32'(pix_x), 32'(m_pix.x));
            check("pix_y", 32'(pix_y), 32'(m_pix.y));
            check("pix_rgb", 32'(pix_rgb), 32'(m_pix.c));
         end
      end
      if (frame_tick) begin
         if (crc_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_frame_tick: got tick with crc=%0h, expected no tick", frame_crc);
         end else begin
            m_crc = crc_q.pop_front();
            check("frame_crc", 32'(frame_crc), 32'(m_crc));
         end
      end
   end

   initial begin
      #12;
      check("reset_locked", 32'(locked), 32'd0);
      check("reset_pix_valid", 32'(pix_valid), 32'd0);
      check("reset_err_cnt", 32'(err_cnt), 32'd0);
      check("reset_frame_crc", 32'(frame_crc), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Acquisition: HUNT->ACQ, good=1, LOCKED on the third vsync edge
      run_frame(1, 0, 0, 16'h0, -1, -1, -1, -1);
      run_frame(1, 0, 0, 16'h0, -1, -1, -1, -1);
      check("unlocked_after_2_edges", 32'(locked), 32'd0);
      run_frame(1, 0, 0, 16'h0, -1, -1, -1, -1);
      check("locked_after_3_edges", 32'(locked), 32'd1);

      run_frame(1, 1, 1, 16'h5000, -1, -1, -1, -1);
      run_frame(2, 1, 1, 16'h8000, -1, -1, -1, -1);
      run_frame(3, 1, 1, 16'h0006, -1, -1, -1, -1);
      run_frame(0, 1, 1, 16'h0000, -1, -1, -1, -1);
      check("clean_err_cnt", 32'(err_cnt), 32'd0);

      // Long line in vertical blanking
      run_frame(1, 1, 1, 16'h5000, 8, -1, -1, -1);
      check("long_line_unlock", 32'(locked), 32'd0);
      check("long_line_err_cnt", 32'(err_cnt), 32'd1);
      run_frame(2, 0, 0, 16'h0, -1, -1, -1, -1);
      run_frame(2, 0, 0, 16'h0, -1, -1, -1, -1);
      check("relock1_pending", 32'(locked), 32'd0);
      run_frame(2, 0, 0, 16'h0, -1, -1, -1, -1);
      check("relock1_done", 32'(locked), 32'd1);

      // Stuck hsync from row 8
      run_frame(3, 1, 1, 16'h0006, -1, 8, -1, -1);
      check("stuck_unlock", 32'(locked), 32'd0);
      check("stuck_err_cnt", 32'(err_cnt), 32'd2);
      run_frame(0, 0, 0, 16'h0, -1, -1, -1, -1);
      run_frame(0, 0, 0, 16'h0, -1, -1, -1, -1);
      check("relock2_pending", 32'(locked), 32'd0);
      run_frame(0, 0, 0, 16'h0, -1, -1, -1, -1);
      check("relock2_done", 32'(locked), 32'd1);

      // p_tick pause mid-blanking must not time out
      run_frame(1, 1, 1, 16'h5000, -1, -1, 8, -1);

      // Mid-frame reset after row 2, then re-acquire
      run_frame(2, 1, 0, 16'h0, -1, -1, -1, 2);
      run_frame(2, 0, 0, 16'h0, -1, -1, -1, -1);
      check("post_reset_unlocked", 32'(locked), 32'd0);
      run_frame(2, 0, 0, 16'h0, -1, -1, -1, -1);
      check("post_reset_relocked", 32'(locked), 32'd1);
      run_frame(0, 1, 1, 16'h0000, -1, -1, -1, -1);
      check("final_err_cnt", 32'(err_cnt), 32'd0);

      repeat (4) @(negedge clk);
      check("pix_q_drained", 32'(pix_q.size()), 32'd0);
      check("crc_q_drained", 32'(crc_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
